// File: rtl/alu_pkg.sv
// Shared definitions for the binary-image ALU path: opcodes, window FSM states,
// default geometry and the window payload carried to the ALU stage.
package alu_pkg;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned COL_W              = 5;
  localparam int unsigned ROW_W              = 9;
  localparam int unsigned DEF_WORDS_PER_ROW  = 20;
  localparam int unsigned DEF_ROWS_PER_FRAME = 480;

  // ALU opcodes understood by the downstream stage
  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_THIN = 4'b1000
  } alu_op_e;

  // Window generator frame-tracking states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } win_state_e;

  // 3-row window presented to the ALU stage
  typedef struct packed {
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] center;
    logic [DATA_W-1:0] bottom;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } window_t;

endpackage

// File: rtl/thin_line_buffer.sv
// Two-row line buffer: lb0 holds row r-1, lb1 holds row r-2. A write at addr
// shifts the old lb0 word into lb1 and stores the new word in lb0.
// Contents are deliberately not reset; the FILL phase overwrites them first.
module thin_line_buffer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_WORDS_PER_ROW,
  parameter int unsigned AW    = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  logic [DATA_W-1:0] lb0 [DEPTH];
  logic [DATA_W-1:0] lb1 [DEPTH];

  // Combinational read of both rows at the current column
  assign rd0 = lb0[addr];
  assign rd1 = lb1[addr];

  // Shift-write: row r-1 moves down to r-2, new word becomes row r-1
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= wdata;
    end
  end

endmodule

// File: rtl/thin_window_gen.sv
// Builds 3-row x 32-pixel windows from a raster stream of binary-pixel words
// and hands them to the thinning ALU stage over a valid/ready interface.
module thin_window_gen
  import alu_pkg::*;
#(
  parameter int unsigned WORDS_PER_ROW  = DEF_WORDS_PER_ROW,
  parameter int unsigned ROWS_PER_FRAME = DEF_ROWS_PER_FRAME
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] center,
  output logic [DATA_W-1:0] bottom,
  output logic [3:0]        alu_control,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              frame_done
);

  localparam int unsigned      LB_AW        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(ROWS_PER_FRAME - 1);
  localparam logic [ROW_W-1:0] LAST_WIN_ROW = ROW_W'(ROWS_PER_FRAME - 2);

  win_state_e        state, state_nxt;
  logic [ROW_W-1:0]  row, row_nxt, pos_row;
  logic [COL_W-1:0]  col, col_nxt, pos_col;
  logic              accept;
  logic              restart;
  logic              lb_we;
  logic              win_load;
  logic              win_take;
  logic              last_win;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  window_t           win_q;

  thin_line_buffer #(
    .DEPTH (WORDS_PER_ROW),
    .AW    (LB_AW)
  ) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .addr  (LB_AW'(pos_col)),
    .wdata (in_data),
    .rd0   (lb0_rd),
    .rd1   (lb1_rd)
  );

  assign top      = win_q.top;
  assign center   = win_q.center;
  assign bottom   = win_q.bottom;
  assign out_row  = win_q.row;
  assign out_col  = win_q.col;
  assign win_take = out_valid && out_ready;
  assign last_win = (win_q.row == LAST_WIN_ROW) && (win_q.col == LAST_COL);

  // State and raster position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // Handshake, raster advance, line-buffer write and next-state decode
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    pos_row   = row;
    pos_col   = col;
    in_ready  = 1'b1;
    accept    = 1'b0;
    restart   = 1'b0;
    lb_we     = 1'b0;
    win_load  = 1'b0;

    // Idle never back-pressures; otherwise only when a window is stuck
    if (state != ST_IDLE) begin
      in_ready = !out_valid || out_ready;
    end
    accept = in_valid && in_ready;

    if (accept) begin
      // A start-of-frame word is always pixel (0,0) of a fresh frame
      if (in_sof) begin
        restart = 1'b1;
        pos_row = '0;
        pos_col = '0;
      end

      if (in_sof || (state != ST_IDLE)) begin
        lb_we = 1'b1;
        if (pos_col == LAST_COL) begin
          col_nxt = '0;
          row_nxt = pos_row + ROW_W'(1);
        end else begin
          col_nxt = pos_col + COL_W'(1);
          row_nxt = pos_row;
        end

        if (restart || (state == ST_FILL)) begin
          // Rows 0 and 1 only prime the line buffers
          state_nxt = ST_FILL;
          if ((pos_row == ROW_W'(1)) && (pos_col == LAST_COL)) begin
            state_nxt = ST_STREAM;
          end
        end else begin
          win_load = 1'b1;
          if ((pos_row == LAST_ROW) && (pos_col == LAST_COL)) begin
            state_nxt = ST_IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
          end
        end
      end
    end
  end

  // Output window register with hold-until-taken semantics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      win_q       <= '0;
      alu_control <= ALU_THIN;
    end else begin
      alu_control <= ALU_THIN;
      frame_done  <= win_take && last_win;
      if (restart && (state != ST_IDLE)) begin
        // Frame aborted: nothing from the old frame may follow
        out_valid <= 1'b0;
      end else if (win_load) begin
        out_valid     <= 1'b1;
        win_q.top     <= lb1_rd;
        win_q.center  <= lb0_rd;
        win_q.bottom  <= in_data;
        win_q.row     <= row - ROW_W'(1);
        win_q.col     <= col;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_thin_window_gen.sv
// Bench for thin_window_gen on a 4x4-word frame: a reset/idle vector table,
// directed frame scenarios and a randomized run against a frame-image model.
module tb_thin_window_gen;

  localparam int W = 4;
  localparam int R = 4;

  typedef struct packed {
    logic [31:0] top;
    logic [31:0] center;
    logic [31:0] bottom;
    logic [8:0]  row;
    logic [4:0]  col;
  } win_t;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } word_t;

  typedef struct packed {
    logic        v;
    logic        sof;
    logic [31:0] d;
    logic        rdy;
    logic        exp_in_ready;
    logic        exp_out_valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] top, center, bottom;
  logic [3:0]  alu_control;
  logic [8:0]  out_row;
  logic [4:0]  out_col;
  logic        frame_done;

  thin_window_gen #(.WORDS_PER_ROW(W), .ROWS_PER_FRAME(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .top(top), .center(center), .bottom(bottom),
    .alu_control(alu_control), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model: the current frame as a 2-D image plus one pending window
  logic [31:0] m_img [R][W];
  logic        m_active;
  int          m_p;
  logic        m_vld;
  win_t        m_win;
  logic        m_fd;

  word_t wq[$];
  win_t  dut_wins[$];
  int    fd_cnt, stall_seen;
  int    stall_row = -1, stall_col = -1, stall_left = 0;
  logic  dflt_ready = 1'b1;
  logic  rand_valid = 1'b0, rand_ready = 1'b0;
  logic  acc;
  int    ncyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_p = 0; m_vld = 1'b0; m_win = '0; m_fd = 1'b0;
  endtask

  function automatic logic model_ready();
    return !m_active || !m_vld || out_ready;
  endfunction

  task automatic model_step(output logic a);
    logic take;
    int r, c;
    take = m_vld && out_ready;
    a    = in_valid && model_ready();
    m_fd = take && (int'(m_win.row) == R - 2) && (int'(m_win.col) == W - 1);
    if (take) m_vld = 1'b0;
    if (a) begin
      if (in_sof) begin
        if (m_active) m_vld = 1'b0;
        m_active = 1'b1;
        m_img[0][0] = in_data;
        m_p = 1;
      end else if (m_active) begin
        r = m_p / W;
        c = m_p % W;
        m_img[r][c] = in_data;
        if (r >= 2) begin
          m_vld = 1'b1;
          m_win = '{top: m_img[r-2][c], center: m_img[r-1][c], bottom: in_data,
                    row: 9'(r - 1), col: 5'(c)};
        end
        m_p++;
        if (m_p == R * W) m_active = 1'b0;
      end
    end
  endtask

  task automatic check_now();
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    chk("alu_control", 64'(alu_control), 64'h8);
    if (m_vld) begin
      chk("top", 64'(top), 64'(m_win.top));
      chk("center", 64'(center), 64'(m_win.center));
      chk("bottom", 64'(bottom), 64'(m_win.bottom));
      chk("out_row", 64'(out_row), 64'(m_win.row));
      chk("out_col", 64'(out_col), 64'(m_win.col));
    end
  endtask

  // One clock: drive at negedge, check DUT against model, advance model
  task automatic cyc(input logic v, input logic s, input logic [31:0] d,
                     input logic r_in, output logic a);
    logic r;
    @(negedge clk);
    r = r_in;
    if (m_vld && int'(m_win.row) == stall_row && int'(m_win.col) == stall_col && stall_left > 0) begin
      r = 1'b0;
      stall_left--;
    end
    in_valid = v; in_sof = s; in_data = d; out_ready = r;
    #1;
    check_now();
    if (out_valid && out_ready) dut_wins.push_back('{top, center, bottom, out_row, out_col});
    if (frame_done) fd_cnt++;
    if (in_valid && !in_ready) stall_seen++;
    model_step(a);
  endtask

  task automatic feed_all(input int budget, output int used);
    logic a, v, r;
    used = 0;
    while (wq.size() > 0 && used < budget) begin
      v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rand_ready ? 1'(($urandom_range(0, 1))) : dflt_ready;
      cyc(v, v ? wq[0].sof : 1'b0, v ? wq[0].data : $urandom, r, a);
      if (a) void'(wq.pop_front());
      used++;
    end
    if (wq.size() > 0) begin
      tests++; failed++;
      $display("FAIL feed_timeout: %0d words left after %0d cycles", wq.size(), used);
      wq.delete();
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, a);
  endtask

  task automatic push_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      wq.push_back('{sof: (i == 0), data: base + 32'((i / W) * 16 + (i % W))});
  endtask

  task automatic clear_stats();
    dut_wins.delete(); fd_cnt = 0; stall_seen = 0;
  endtask

  task automatic chk_win(input string name, input win_t act, input win_t exp);
    chk(name, 64'(act.top ^ {act.row, act.col, 18'h0}) ^ {act.center, act.bottom},
        64'(exp.top ^ {exp.row, exp.col, 18'h0}) ^ {exp.center, exp.bottom});
  endtask

  vec_t tbl [6];

  initial begin
    model_reset();
    clear_stats();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_top", 64'(top), 64'h0);
    chk("rst_center", 64'(center), 64'h0);
    chk("rst_bottom", 64'(bottom), 64'h0);
    chk("rst_out_row", 64'(out_row), 64'h0);
    chk("rst_out_col", 64'(out_col), 64'h0);
    chk("rst_alu_control", 64'(alu_control), 64'h8);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;

    // Idle: words without start-of-frame are all dropped
    tbl[0] = '{1'b1, 1'b0, 32'hDEAD0000, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'hDEAD0002, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'hDEAD0003, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'hDEAD0004, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'hDEAD0005, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_sof = tbl[i].sof; in_data = tbl[i].d; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_in_ready));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_out_valid));
      model_step(acc);
    end

    // Plain frame, downstream always ready
    clear_stats();
    push_frame(32'h0, 16);
    feed_all(100, ncyc);
    idle(3);
    chk("f1_win_count", 64'(dut_wins.size()), 64'd8);
    chk("f1_frame_done_count", 64'(fd_cnt), 64'd1);
    if (dut_wins.size() == 8) begin
      chk_win("f1_first_win", dut_wins[0], '{32'h00, 32'h10, 32'h20, 9'd1, 5'd0});
      chk_win("f1_last_win", dut_wins[7], '{32'h13, 32'h23, 32'h33, 9'd2, 5'd3});
    end

    // Same frame, downstream stalls 3 cycles on window (1,2)
    clear_stats();
    stall_row = 1; stall_col = 2; stall_left = 3;
    push_frame(32'h0, 16);
    feed_all(100, ncyc);
    idle(3);
    stall_row = -1; stall_col = -1;
    chk("f2_win_count", 64'(dut_wins.size()), 64'd8);
    chk("f2_frame_done_count", 64'(fd_cnt), 64'd1);
    chk("f2_in_ready_low_cycles", 64'(stall_seen), 64'd3);
    if (dut_wins.size() == 8) begin
      chk_win("f2_win_1_2", dut_wins[2], '{32'h02, 32'h12, 32'h22, 9'd1, 5'd2});
      chk_win("f2_win_1_3", dut_wins[3], '{32'h03, 32'h13, 32'h23, 9'd1, 5'd3});
    end

    // New start-of-frame at row 2, col 1 aborts the old frame
    clear_stats();
    push_frame(32'h0, 9);
    push_frame(32'h100, 16);
    feed_all(100, ncyc);
    idle(3);
    chk("ab_win_count", 64'(dut_wins.size()), 64'd9);
    chk("ab_frame_done_count", 64'(fd_cnt), 64'd1);
    if (dut_wins.size() == 9) begin
      chk_win("ab_old_win", dut_wins[0], '{32'h00, 32'h10, 32'h20, 9'd1, 5'd0});
      chk_win("ab_new_first", dut_wins[1], '{32'h100, 32'h110, 32'h120, 9'd1, 5'd0});
      chk_win("ab_new_last", dut_wins[8], '{32'h113, 32'h123, 32'h133, 9'd2, 5'd3});
    end

    // Reset while a window is pending
    clear_stats();
    dflt_ready = 1'b0;
    push_frame(32'h0, 9);
    feed_all(100, ncyc);
    dflt_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("mr_pending_valid", 64'(out_valid), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'h0);
    chk("mr_alu_control", 64'(alu_control), 64'h8);
    chk("mr_in_ready", 64'(in_ready), 64'h1);
    chk("mr_out_row", 64'(out_row), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 6; i++) wq.push_back('{sof: 1'b0, data: 32'hBAD0 + 32'(i)});
    feed_all(50, ncyc);
    idle(2);
    chk("mr_no_windows", 64'(dut_wins.size()), 64'd0);

    // Back-to-back frames with continuous input
    clear_stats();
    push_frame(32'h0, 16);
    push_frame(32'h200, 16);
    feed_all(100, ncyc);
    idle(3);
    chk("bb_cycles", 64'(ncyc), 64'd32);
    chk("bb_win_count", 64'(dut_wins.size()), 64'd16);
    chk("bb_frame_done_count", 64'(fd_cnt), 64'd2);

    // Randomized traffic, junk words and truncated frames
    rand_valid = 1'b1; rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        wq.push_back('{sof: 1'b0, data: $urandom});
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      for (int i = 0; i < n; i++) wq.push_back('{sof: (i == 0), data: $urandom});
    end
    feed_all(5000, ncyc);
    rand_valid = 1'b0; rand_ready = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
